juez_nivel: RTL and testbench
=============================

Name: juez_nivel

Overview:
Judging block for a Drums Hero level. It compares drum-pad hits against the note windows from the note scroller, counts hits, misses and score, and drives `Perdio` back to the level state machine. It consumes that machine's `Stop` level (high while the game is in its initial state) and closes the start/lose loop with it.

Parameters:
N_CARRILES, 4, number of drum lanes
MAX_FALLOS, 8, miss count that ends the game (1..15)
PTS_ACIERTO, 10, points per hit
RACHA_X2, 5, streak length at which hits score double
W_PUNTAJE, 12, score width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
Stop  in  1  high while the level machine is in its initial state
nota_valida  in  N_CARRILES  per lane: a note is inside the hit zone (multi-cycle window)
golpe  in  N_CARRILES  per lane: debounced pad level (pressed = 1)
Perdio  out  1  game lost; level, registered
puntaje  out  W_PUNTAJE  accumulated score, saturating
fallos  out  4  accumulated misses, saturating at MAX_FALLOS
racha  out  8  current consecutive-hit streak, saturating at 255

Behaviour:
- One clock domain, `clk`. `reset` is synchronous and active-high.
- Reset, including mid-game: state=IDLE, Perdio=0, puntaje=0, fallos=0, racha=0, all edge/flag registers=0.
- States:
  - IDLE: Perdio=0; counters hold their last values for display. IDLE->JUGANDO when Stop==0; puntaje, fallos and racha clear on that same edge.
  - JUGANDO: events are counted. ->PERDIDO when the updated fallos reaches MAX_FALLOS. ->IDLE when Stop==1 (abort); Perdio stays 0.
  - PERDIDO: Perdio=1; counters frozen; all events ignored. ->IDLE only when Stop==1.
- Perdio equals (state==PERDIDO). It rises exactly one clock after the edge on which fallos reached MAX_FALLOS.
- Per-lane detection (registered previous values g_q and n_q):
  - golpe_edge = golpe & ~g_q.
  - fin_ventana = n_q & ~nota_valida.
  - A flag `acertado` sets on a hit and clears at fin_ventana.
- Per-lane events, evaluated only in JUGANDO:
  - acierto: golpe_edge & (nota_valida | n_q) & ~acertado. A press in the same cycle the window closes still counts as a hit.
  - fallo_golpe: golpe_edge & ~nota_valida & ~n_q (press with no note).
  - fallo_nota: fin_ventana & ~acertado & ~acierto (note passed unhit).
  - A second press inside an already-hit window is ignored: no hit, no miss.
- Per-cycle update (all lanes summed; all counter updates registered):
  - nA = hits, nF = misses.
  - fallos <= min(fallos+nF, MAX_FALLOS).
  - racha: if nF>0 then 0, else min(racha+nA, 255). A miss wins over a hit in the same cycle.
  - puntaje <= sat(puntaje + nA*PTS_ACIERTO*(racha>=RACHA_X2 ? 2 : 1)). The multiplier uses the pre-update racha; the sum saturates at 2^W_PUNTAJE-1.
- Edge registers update in every state, so a pad held across a state change does not produce a spurious edge.

Decomposition:
- Package `juez_pkg`:
  - state encodings IDLE=0, JUGANDO=1, PERDIDO=2 (2-bit);
  - default constants for MAX_FALLOS, PTS_ACIERTO and RACHA_X2;
  - a saturating-add function.
- Sub-module `detector_carril`, instantiated N_CARRILES times:
  - inputs: clk, reset, habilitar (state==JUGANDO), nota_valida, golpe;
  - outputs: acierto and fallo pulses;
  - contains g_q, n_q and acertado.
- The top holds the state machine, popcount/sum logic and counters.

Test Plan:
- Start: reset, Stop=1 for 3 cycles, then 0 -> state JUGANDO on the next edge, counters 0, Perdio=0.
- Lane 0 window open 6 cycles, press on cycle 2 -> acierto once; puntaje=10, racha=1, fallos=0. A second press in the same window -> no change.
- Streak: 6 consecutive hit windows -> puntaje=10*5+20=70 (sixth hit doubled), racha=6. Then one empty-lane press -> fallos=1, racha=0.
- Simultaneous events: lane 1 hit and lane 2 unhit window end in the same cycle -> puntaje +10, fallos +1, racha=0.
- Lose: 8 unhit windows with MAX_FALLOS=8 -> fallos saturates at 8, Perdio=1 one cycle after; further presses change nothing. Stop=1 -> IDLE, Perdio=0; Stop=0 -> counters cleared.
- Abort/reset: Stop=1 mid-game with fallos=3 -> IDLE, Perdio never rises, fallos holds 3. Reset asserted mid-game -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/juez_pkg.sv
// Shared definitions for the Drums Hero level judge: state encoding,
// default tuning constants and a saturating adder used by the counters.
package juez_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        JUGANDO = 2'd1,
        PERDIDO = 2'd2
    } estado_t;

    localparam int N_CARRILES_DEF  = 4;
    localparam int MAX_FALLOS_DEF  = 8;
    localparam int PTS_ACIERTO_DEF = 10;
    localparam int RACHA_X2_DEF    = 5;
    localparam int W_PUNTAJE_DEF   = 12;

    // Unsigned add clamped to 'tope'; operands are widened by one bit so the
    // carry out of 32 bits is never lost before the comparison.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] tope
    );
        logic [32:0] suma;
        suma = {1'b0, a} + {1'b0, b};
        if (suma > {1'b0, tope}) begin
            sat_add = tope;
        end else begin
            sat_add = suma[31:0];
        end
    endfunction

endpackage

// File: rtl/juez_nivel_detector_carril.sv
// One drum lane: edge detection of the pad, end-of-window detection of the
// note, and classification of each event into a hit or a miss pulse.
module detector_carril
    import juez_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic habilitar,
    input  logic nota_valida,
    input  logic golpe,
    output logic acierto,
    output logic fallo
);

    logic g_q_r;
    logic n_q_r;
    logic acertado_r;
    logic golpe_edge_s;
    logic fin_ventana_s;
    logic acierto_s;
    logic fallo_s;

    // Classify the current cycle's pad/note activity into hit and miss events.
    always_comb begin
        golpe_edge_s  = golpe & ~g_q_r;
        fin_ventana_s = n_q_r & ~nota_valida;
        if (habilitar) begin
            // A press on the very cycle the window closes still sees n_q_r.
            acierto_s = golpe_edge_s & (nota_valida | n_q_r) & ~acertado_r;
            fallo_s   = (golpe_edge_s & ~nota_valida & ~n_q_r)
                      | (fin_ventana_s & ~acertado_r & ~acierto_s);
        end else begin
            acierto_s = 1'b0;
            fallo_s   = 1'b0;
        end
    end

    assign acierto = acierto_s;
    assign fallo   = fallo_s;

    // Previous-value registers run in every state so a held pad never looks
    // like a fresh press after a state change; the hit flag lives per window.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_q_r      <= 1'b0;
            n_q_r      <= 1'b0;
            acertado_r <= 1'b0;
        end else begin
            g_q_r <= golpe;
            n_q_r <= nota_valida;
            // Window end wins so the next window always starts un-hit.
            if (fin_ventana_s) begin
                acertado_r <= 1'b0;
            end else if (acierto_s) begin
                acertado_r <= 1'b1;
            end else begin
                acertado_r <= acertado_r;
            end
        end
    end

endmodule

// File: rtl/juez_nivel.sv
// Level judge: runs the IDLE/JUGANDO/PERDIDO game machine, sums per-lane
// hit/miss pulses and keeps saturating score, miss and streak counters.
module juez_nivel
    import juez_pkg::*;
#(
    parameter int N_CARRILES  = N_CARRILES_DEF,
    parameter int MAX_FALLOS  = MAX_FALLOS_DEF,
    parameter int PTS_ACIERTO = PTS_ACIERTO_DEF,
    parameter int RACHA_X2    = RACHA_X2_DEF,
    parameter int W_PUNTAJE   = W_PUNTAJE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stop,
    input  logic [N_CARRILES-1:0] nota_valida,
    input  logic [N_CARRILES-1:0] golpe,
    output logic                  Perdio,
    output logic [W_PUNTAJE-1:0]  puntaje,
    output logic [3:0]            fallos,
    output logic [7:0]            racha
);

    localparam logic [3:0]  MAX_F4    = 4'(MAX_FALLOS);
    localparam logic [31:0] MAX_F32   = 32'(MAX_FALLOS);
    localparam logic [31:0] PUNT_MAX  = 32'((64'd1 << W_PUNTAJE) - 64'd1);
    localparam logic [31:0] RACHA_MAX = 32'd255;

    estado_t                 estado_r;
    logic                    habilitar_s;
    logic [N_CARRILES-1:0]   acierto_s;
    logic [N_CARRILES-1:0]   fallo_s;
    logic [7:0]              n_a_s;
    logic [7:0]              n_f_s;
    logic [31:0]             fallos_sum_s;
    logic [31:0]             racha_sum_s;
    logic [31:0]             factor_s;
    logic [31:0]             incremento_s;
    logic [31:0]             puntaje_sum_s;
    logic [3:0]              fallos_nxt_s;
    logic [7:0]              racha_nxt_s;
    logic [W_PUNTAJE-1:0]    puntaje_nxt_s;
    logic                    unused_bits_s;

    // Events count only while playing and before the miss limit is reached,
    // so the cycle between hitting the limit and entering PERDIDO is frozen.
    always_comb begin
        if ((estado_r == JUGANDO) && (fallos < MAX_F4)) begin
            habilitar_s = 1'b1;
        end else begin
            habilitar_s = 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CARRILES; gi++) begin : g_carril
            detector_carril u_detector (
                .clk         (clk),
                .reset       (reset),
                .habilitar   (habilitar_s),
                .nota_valida (nota_valida[gi]),
                .golpe       (golpe[gi]),
                .acierto     (acierto_s[gi]),
                .fallo       (fallo_s[gi])
            );
        end
    endgenerate

    // Count hits and misses across all lanes this cycle.
    always_comb begin
        n_a_s = 8'd0;
        n_f_s = 8'd0;
        for (int i = 0; i < N_CARRILES; i++) begin
            n_a_s = n_a_s + {7'd0, acierto_s[i]};
            n_f_s = n_f_s + {7'd0, fallo_s[i]};
        end
    end

    // Next counter values; the score multiplier looks at the streak before
    // this cycle's update, and any miss resets the streak even with hits.
    always_comb begin
        fallos_sum_s = sat_add({28'd0, fallos}, {24'd0, n_f_s}, MAX_F32);
        fallos_nxt_s = fallos_sum_s[3:0];
        racha_sum_s  = sat_add({24'd0, racha}, {24'd0, n_a_s}, RACHA_MAX);
        if (n_f_s != 8'd0) begin
            racha_nxt_s = 8'd0;
        end else begin
            racha_nxt_s = racha_sum_s[7:0];
        end
        if (racha >= 8'(RACHA_X2)) begin
            factor_s = 32'd2;
        end else begin
            factor_s = 32'd1;
        end
        incremento_s  = {24'd0, n_a_s} * 32'(PTS_ACIERTO) * factor_s;
        puntaje_sum_s = sat_add(32'(puntaje), incremento_s, PUNT_MAX);
        puntaje_nxt_s = puntaje_sum_s[W_PUNTAJE-1:0];
    end

    assign unused_bits_s = ^{fallos_sum_s[31:4], racha_sum_s[31:8], puntaje_sum_s};

    // Game machine with registered Perdio and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r <= IDLE;
            Perdio   <= 1'b0;
            puntaje  <= '0;
            fallos   <= 4'd0;
            racha    <= 8'd0;
        end else begin
            case (estado_r)
                IDLE: begin
                    Perdio <= 1'b0;
                    if (!Stop) begin
                        estado_r <= JUGANDO;
                        puntaje  <= '0;
                        fallos   <= 4'd0;
                        racha    <= 8'd0;
                    end else begin
                        estado_r <= IDLE;
                    end
                end
                JUGANDO: begin
                    if (Stop) begin
                        estado_r <= IDLE;
                        Perdio   <= 1'b0;
                    end else if (fallos >= MAX_F4) begin
                        estado_r <= PERDIDO;
                        Perdio   <= 1'b1;
                    end else begin
                        estado_r <= JUGANDO;
                        Perdio   <= 1'b0;
                        puntaje  <= puntaje_nxt_s;
                        fallos   <= fallos_nxt_s;
                        racha    <= racha_nxt_s;
                    end
                end
                PERDIDO: begin
                    if (Stop) begin
                        estado_r <= IDLE;
                        Perdio   <= 1'b0;
                    end else begin
                        estado_r <= PERDIDO;
                        Perdio   <= 1'b1;
                    end
                end
                default: begin
                    estado_r <= IDLE;
                    Perdio   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_juez_nivel.sv
// Directed self-checking bench for juez_nivel with hand-computed results.
module tb_juez_nivel;

    logic        clk;
    logic        reset;
    logic        Stop;
    logic [3:0]  nota_valida;
    logic [3:0]  golpe;
    logic        Perdio;
    logic [11:0] puntaje;
    logic [3:0]  fallos;
    logic [7:0]  racha;

    int vectors;
    int errors;

    juez_nivel dut (
        .clk         (clk),
        .reset       (reset),
        .Stop        (Stop),
        .nota_valida (nota_valida),
        .golpe       (golpe),
        .Perdio      (Perdio),
        .puntaje     (puntaje),
        .fallos      (fallos),
        .racha       (racha)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hit_window(input int lane);
        nota_valida[lane] = 1'b1; tick();
        golpe[lane] = 1'b1;       tick();
        golpe[lane] = 1'b0;       tick();
        nota_valida[lane] = 1'b0; tick();
        tick();
    endtask

    task automatic restart();
        Stop = 1'b1; tick();
        Stop = 1'b0; tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; Stop = 1'b1; nota_valida = 4'd0; golpe = 4'd0;
        tick(); tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd0, 8'd0, 12'd0}) begin
            errors++;
            $display("FAIL reset: got P=%0b F=%0d R=%0d S=%0d want all 0", Perdio, fallos, racha, puntaje);
        end
        reset = 1'b0;
    endtask

    task automatic test_start();
        Stop = 1'b1; tick(); tick(); tick();
        Stop = 1'b0; tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd0, 8'd0, 12'd0}) begin
            errors++;
            $display("FAIL start: got P=%0b F=%0d R=%0d S=%0d want all 0", Perdio, fallos, racha, puntaje);
        end
    endtask

    task automatic test_hit();
        nota_valida[0] = 1'b1; tick();
        golpe[0] = 1'b1; tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd0, 8'd1, 12'd10}) begin
            errors++;
            $display("FAIL hit_first: got P=%0b F=%0d R=%0d S=%0d want P=0 F=0 R=1 S=10", Perdio, fallos, racha, puntaje);
        end
        golpe[0] = 1'b0; tick();
        golpe[0] = 1'b1; tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd0, 8'd1, 12'd10}) begin
            errors++;
            $display("FAIL hit_second_press: got P=%0b F=%0d R=%0d S=%0d want P=0 F=0 R=1 S=10", Perdio, fallos, racha, puntaje);
        end
        golpe[0] = 1'b0; tick(); tick();
        nota_valida[0] = 1'b0; tick(); tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd0, 8'd1, 12'd10}) begin
            errors++;
            $display("FAIL hit_window_end: got P=%0b F=%0d R=%0d S=%0d want P=0 F=0 R=1 S=10", Perdio, fallos, racha, puntaje);
        end
    endtask

    task automatic test_streak();
        restart();
        for (int k = 0; k < 5; k++) hit_window(k % 4);
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd0, 8'd5, 12'd50}) begin
            errors++;
            $display("FAIL streak_5: got P=%0b F=%0d R=%0d S=%0d want P=0 F=0 R=5 S=50", Perdio, fallos, racha, puntaje);
        end
        hit_window(1);
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd0, 8'd6, 12'd70}) begin
            errors++;
            $display("FAIL streak_6: got P=%0b F=%0d R=%0d S=%0d want P=0 F=0 R=6 S=70", Perdio, fallos, racha, puntaje);
        end
        golpe[3] = 1'b1; tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd1, 8'd0, 12'd70}) begin
            errors++;
            $display("FAIL empty_press: got P=%0b F=%0d R=%0d S=%0d want P=0 F=1 R=0 S=70", Perdio, fallos, racha, puntaje);
        end
        golpe[3] = 1'b0; tick();
    endtask

    task automatic test_simultaneous();
        nota_valida[2] = 1'b1; tick(); tick();
        nota_valida[1] = 1'b1; tick();
        nota_valida[2] = 1'b0; golpe[1] = 1'b1; tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd2, 8'd0, 12'd80}) begin
            errors++;
            $display("FAIL simultaneous: got P=%0b F=%0d R=%0d S=%0d want P=0 F=2 R=0 S=80", Perdio, fallos, racha, puntaje);
        end
        golpe[1] = 1'b0; nota_valida[1] = 1'b0; tick(); tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd2, 8'd0, 12'd80}) begin
            errors++;
            $display("FAIL simultaneous_after: got P=%0b F=%0d R=%0d S=%0d want P=0 F=2 R=0 S=80", Perdio, fallos, racha, puntaje);
        end
        // press on the cycle the window closes
        nota_valida[0] = 1'b1; tick();
        nota_valida[0] = 1'b0; golpe[0] = 1'b1; tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd2, 8'd1, 12'd90}) begin
            errors++;
            $display("FAIL late_press: got P=%0b F=%0d R=%0d S=%0d want P=0 F=2 R=1 S=90", Perdio, fallos, racha, puntaje);
        end
        golpe[0] = 1'b0; tick(); tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd2, 8'd1, 12'd90}) begin
            errors++;
            $display("FAIL late_press_after: got P=%0b F=%0d R=%0d S=%0d want P=0 F=2 R=1 S=90", Perdio, fallos, racha, puntaje);
        end
        hit_window(0);
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd2, 8'd2, 12'd100}) begin
            errors++;
            $display("FAIL next_window: got P=%0b F=%0d R=%0d S=%0d want P=0 F=2 R=2 S=100", Perdio, fallos, racha, puntaje);
        end
    endtask

    task automatic test_lose();
        restart();
        for (int k = 1; k <= 8; k++) begin
            nota_valida[0] = 1'b1; tick();
            nota_valida[0] = 1'b0; tick();
            if (k == 7) begin
                vectors++;
                if ({Perdio, fallos} !== {1'b0, 4'd7}) begin
                    errors++;
                    $display("FAIL lose_7: got P=%0b F=%0d want P=0 F=7", Perdio, fallos);
                end
            end
        end
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd8, 8'd0, 12'd0}) begin
            errors++;
            $display("FAIL lose_8: got P=%0b F=%0d R=%0d S=%0d want P=0 F=8 R=0 S=0", Perdio, fallos, racha, puntaje);
        end
        tick();
        vectors++;
        if ({Perdio, fallos} !== {1'b1, 4'd8}) begin
            errors++;
            $display("FAIL lose_perdio: got P=%0b F=%0d want P=1 F=8", Perdio, fallos);
        end
        golpe[0] = 1'b1; tick();
        golpe[0] = 1'b0; tick();
        hit_window(1);
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b1, 4'd8, 8'd0, 12'd0}) begin
            errors++;
            $display("FAIL lose_frozen: got P=%0b F=%0d R=%0d S=%0d want P=1 F=8 R=0 S=0", Perdio, fallos, racha, puntaje);
        end
        Stop = 1'b1; tick();
        vectors++;
        if ({Perdio, fallos} !== {1'b0, 4'd8}) begin
            errors++;
            $display("FAIL lose_stop: got P=%0b F=%0d want P=0 F=8", Perdio, fallos);
        end
        Stop = 1'b0; tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd0, 8'd0, 12'd0}) begin
            errors++;
            $display("FAIL lose_restart: got P=%0b F=%0d R=%0d S=%0d want all 0", Perdio, fallos, racha, puntaje);
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < 3; k++) begin
            golpe[3] = 1'b1; tick();
            golpe[3] = 1'b0; tick();
        end
        vectors++;
        if ({Perdio, fallos} !== {1'b0, 4'd3}) begin
            errors++;
            $display("FAIL abort_pre: got P=%0b F=%0d want P=0 F=3", Perdio, fallos);
        end
        Stop = 1'b1; tick();
        vectors++;
        if ({Perdio, fallos} !== {1'b0, 4'd3}) begin
            errors++;
            $display("FAIL abort_stop: got P=%0b F=%0d want P=0 F=3", Perdio, fallos);
        end
        golpe[2] = 1'b1; tick(); tick();
        vectors++;
        if ({Perdio, fallos} !== {1'b0, 4'd3}) begin
            errors++;
            $display("FAIL abort_hold: got P=%0b F=%0d want P=0 F=3", Perdio, fallos);
        end
        // pad held across the IDLE->JUGANDO change must not count
        Stop = 1'b0; tick(); tick(); tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd0, 8'd0, 12'd0}) begin
            errors++;
            $display("FAIL held_pad: got P=%0b F=%0d R=%0d S=%0d want all 0", Perdio, fallos, racha, puntaje);
        end
        golpe[2] = 1'b0; tick();
        hit_window(1);
        golpe[3] = 1'b1; tick();
        golpe[3] = 1'b0;
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd1, 8'd0, 12'd10}) begin
            errors++;
            $display("FAIL pre_reset: got P=%0b F=%0d R=%0d S=%0d want P=0 F=1 R=0 S=10", Perdio, fallos, racha, puntaje);
        end
        reset = 1'b1; tick();
        vectors++;
        if ({Perdio, fallos, racha, puntaje} !== {1'b0, 4'd0, 8'd0, 12'd0}) begin
            errors++;
            $display("FAIL midgame_reset: got P=%0b F=%0d R=%0d S=%0d want all 0", Perdio, fallos, racha, puntaje);
        end
        reset = 1'b0; tick();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset = 1'b1; Stop = 1'b1; nota_valida = 4'd0; golpe = 4'd0;
        test_reset();
        test_start();
        test_hit();
        test_streak();
        test_simultaneous();
        test_lose();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
